// File: rtl/aes_pkg.sv
// Shared AES-128 decrypt definitions: round count, FSM encoding and the
// GF(2^8) helpers used by the inverse round datapath.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } fsm_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = '0;
    p   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++)
      r[127 - 32*c -: 32] = inv_mix_column(s[127 - 32*c -: 32]);
    return r;
  endfunction

  // Byte k sits at [127-8k -: 8]; row r of column c is byte r+4c.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int unsigned row = 0; row < 4; row++)
      for (int unsigned col = 0; col < 4; col++)
        r[127 - 8*(row + 4*col) -: 8] = s[127 - 8*(row + 4*((col + 4 - row) % 4)) -: 8];
    return r;
  endfunction

endpackage

// File: rtl/InvSubWord.sv
// Inverse AES S-box for one byte, the decrypt-side mirror of SubWord.
module InvSubWord (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);
  import aes_pkg::*;

  // Field inverse as x^254 (maps 0 to 0); pure function of the input, so it folds to a table.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] e;
    r = 8'h01;
    p = x;
    e = 8'hfe;
    for (int unsigned i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, p);
      p = gf_mul(p, p);
    end
    return r;
  endfunction

  logic [7:0] pre_inv;

  always_comb begin
    pre_inv  = {in_byte[6:0], in_byte[7]} ^ {in_byte[4:0], in_byte[7:5]} ^
               {in_byte[1:0], in_byte[7:2]} ^ 8'h05;
    out_byte = gf_inv(pre_inv);
  end

endmodule

// File: rtl/decrypt_iterative_core.sv
// Iterative AES-128 inverse cipher: one inverse round per clock, round keys
// fetched from an external combinational expanded-key store via roundIdx.
module decrypt_iterative_core #(
  parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [127:0] inputData,
  input  logic [127:0] roundKey,
  output logic [3:0]   roundIdx,
  output logic         busy,
  output logic         done,
  output logic [127:0] outputData
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  fsm_t         fsm_q, fsm_d;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] state_q, state_d;
  logic [127:0] out_q, out_d;
  logic         done_q, done_d;

  logic [127:0] isr;
  logic [127:0] isb;
  logic [127:0] ark;
  logic [127:0] round_out;

  assign isr = inv_shift_rows(state_q);

  for (genvar i = 0; i < 16; i++) begin : g_isb
    InvSubWord u_isb (
      .in_byte  (isr[127 - 8*i -: 8]),
      .out_byte (isb[127 - 8*i -: 8])
    );
  end

  // ROUND and FINAL share the datapath; FINAL skips InvMixColumns.
  always_comb begin
    ark       = isb ^ roundKey;
    round_out = (fsm_q == ST_FINAL) ? ark : inv_mix_columns(ark);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fsm_q   <= ST_IDLE;
      idx_q   <= LAST_IDX;
      state_q <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:  if (start) fsm_d = ST_ROUND;
      ST_ROUND: if (idx_q == 4'd1) fsm_d = ST_FINAL;
      ST_FINAL: fsm_d = ST_IDLE;
      default:  fsm_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d   = idx_q;
    state_d = state_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          state_d = inputData ^ roundKey;
          idx_d   = LAST_IDX - 4'd1;
        end
      end
      ST_ROUND: begin
        state_d = round_out;
        idx_d   = idx_q - 4'd1;
      end
      ST_FINAL: begin
        out_d  = round_out;
        done_d = 1'b1;
        idx_d  = LAST_IDX;
      end
      default: idx_d = LAST_IDX;
    endcase
  end

  always_comb begin
    busy       = (fsm_q != ST_IDLE);
    done       = done_q;
    roundIdx   = idx_q;
    outputData = out_q;
  end

endmodule

// File: tb/tb_decrypt_iterative_core.sv
// Self-checking bench: key-store and forward-cipher model; plaintexts are
// recovered by encrypting reference blocks and expecting the DUT to invert them.
module tb_decrypt_iterative_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] in_data = '0;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;
  logic [127:0] out_data;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] rk [16];
  logic [3:0]   idx_trace [12];
  logic         busy_trace [12];

  always #5 clk = ~clk;

  assign round_key = rk[round_idx];

  decrypt_iterative_core #(.NUM_ROUNDS(10)) dut (
    .CLK        (clk),
    .RST        (rst),
    .start      (start),
    .inputData  (in_data),
    .roundKey   (round_key),
    .roundIdx   (round_idx),
    .busy       (busy),
    .done       (done),
    .outputData (out_data)
  );

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
          {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[x] = s;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[0][127 - 8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r + 4*c] = t[r + 4*((c + r) % 4)];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[rnd][127 - 8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one block from an idle cycle and records what the DUT shows each cycle.
  task automatic run_block(input logic [127:0] ct, input bit mutate, input bit poke,
                           output int done_cyc, output logic [127:0] pt);
    done_cyc = -1;
    pt       = '0;
    start    = 1'b1;
    in_data  = ct;
    for (int c = 0; c <= 16; c++) begin
      if (c < 12) begin
        idx_trace[c]  = round_idx;
        busy_trace[c] = busy;
      end
      if (c > 0 && done === 1'b1) begin
        done_cyc = c;
        pt       = out_data;
        break;
      end
      tick();
      start = poke && (c + 1 == 3 || c + 1 == 7);
      if (mutate) in_data = '1;
      else if (poke) in_data = {$urandom, $urandom, $urandom, $urandom};
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if (round_idx !== 4'd10 || busy !== 1'b0 || done !== 1'b0 || out_data !== 128'h0) begin
      miscompares++;
      $display("FAIL reset: idx=%0d busy=%b done=%b out=%h, required idx=10 busy=0 done=0 out=0",
               round_idx, busy, done, out_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips_c1();
    int cyc;
    logic [127:0] pt;
    set_key(C1_KEY);
    run_block(C1_CT, 1'b0, 1'b0, cyc, pt);
    vectors++;
    if (cyc !== 11) begin
      miscompares++;
      $display("FAIL c1_latency: done at cycle %0d, required 11", cyc);
    end
    vectors++;
    if (pt !== C1_PT) begin
      miscompares++;
      $display("FAIL c1_plaintext: got %h, required %h", pt, C1_PT);
    end
    for (int c = 0; c < 12; c++) begin
      vectors++;
      if (idx_trace[c] !== ((c == 11) ? 4'd10 : 4'(10 - c))) begin
        miscompares++;
        $display("FAIL c1_round_idx[%0d]: got %0d, required %0d", c, idx_trace[c],
                 (c == 11) ? 10 : 10 - c);
      end
      vectors++;
      if (busy_trace[c] !== (c >= 1 && c <= 10)) begin
        miscompares++;
        $display("FAIL c1_busy[%0d]: got %b, required %b", c, busy_trace[c], (c >= 1 && c <= 10));
      end
    end
    tick();
    vectors++;
    if (done !== 1'b0 || out_data !== C1_PT) begin
      miscompares++;
      $display("FAIL c1_hold: done=%b out=%h, required done=0 out=%h", done, out_data, C1_PT);
    end
  endtask

  task automatic test_fips_b();
    int cyc;
    logic [127:0] pt;
    set_key(B_KEY);
    run_block(B_CT, 1'b0, 1'b0, cyc, pt);
    vectors++;
    if (cyc !== 11 || pt !== B_PT) begin
      miscompares++;
      $display("FAIL appb: cycle %0d out %h, required cycle 11 out %h", cyc, pt, B_PT);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int c1, c2;
    logic [127:0] p1, p2;
    set_key(C1_KEY);
    run_block(C1_CT, 1'b0, 1'b1, c1, p1);
    set_key(B_KEY);
    run_block(B_CT, 1'b0, 1'b1, c2, p2);
    vectors++;
    if (c1 !== 11 || p1 !== C1_PT) begin
      miscompares++;
      $display("FAIL b2b_first: cycle %0d out %h, required cycle 11 out %h", c1, p1, C1_PT);
    end
    vectors++;
    if (c2 !== 11 || p2 !== B_PT) begin
      miscompares++;
      $display("FAIL b2b_second: cycle %0d out %h, required cycle 11 out %h", c2, p2, B_PT);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int stray;
    logic [127:0] pt;
    set_key(C1_KEY);
    start = 1'b1; in_data = C1_CT;
    tick();
    start = 1'b0;
    for (int c = 2; c <= 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || out_data !== 128'h0 || round_idx !== 4'd10) begin
      miscompares++;
      $display("FAIL rst_mid: busy=%b done=%b out=%h idx=%0d, required 0 0 0 10",
               busy, done, out_data, round_idx);
    end
    stray = 0;
    for (int c = 0; c < 15; c++) begin
      if (done === 1'b1 || busy === 1'b1) stray++;
      tick();
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_quiet: %0d active cycles after abort, required 0", stray);
    end
    // Reset and start together: start must be dropped.
    rst = 1'b1; start = 1'b1; in_data = B_CT;
    tick();
    rst = 1'b0; start = 1'b0;
    stray = 0;
    for (int c = 0; c < 13; c++) begin
      if (done === 1'b1 || busy === 1'b1) stray++;
      tick();
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("FAIL rst_with_start: %0d active cycles, required 0", stray);
    end
    run_block(C1_CT, 1'b0, 1'b0, cyc, pt);
    vectors++;
    if (cyc !== 11 || pt !== C1_PT) begin
      miscompares++;
      $display("FAIL rst_recover: cycle %0d out %h, required cycle 11 out %h", cyc, pt, C1_PT);
    end
    tick();
  endtask

  task automatic test_random();
    int cyc;
    logic [127:0] key, pt, ct, got;
    for (int n = 0; n < 8; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      set_key(key);
      ct = encrypt(pt);
      run_block(ct, 1'b1, 1'b0, cyc, got);
      vectors++;
      if (cyc !== 11 || got !== pt) begin
        miscompares++;
        $display("FAIL random[%0d]: cycle %0d out %h, required cycle 11 out %h", n, cyc, got, pt);
      end
      if (n % 2 == 1) tick();
    end
  endtask

  initial begin
    init_sbox();
    set_key(C1_KEY);
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
